fpu_test_sequencer: RTL
=======================

# fpu_test_sequencer

Board-level controller that steps the FPU through the stored operand-pair table, one vector per button press. It addresses the operand memory, issues a one-cycle start to the FPU, waits for completion with a timeout, and latches the result for display. It sits between the debounced push-button, the operand table (combinational read by index) and the FPU core on the FPGA test top.

## Interface
- NUM_VECTORS, 10, entries in the operand table; index wraps from NUM_VECTORS-1 to 0
- IDX_W, 4, index width (≥ clog2(NUM_VECTORS))
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level change
- TIMEOUT_CYCLES, 64, maximum cycles spent in WAIT before a timeout is declared

- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- btn_raw  input  1  asynchronous push-button level, active-high
- vec_idx  output  IDX_W  operand table address; operands A/B are valid combinationally in the same cycle
- fpu_start  output  1  one-cycle start strobe to the FPU
- fpu_done  input  1  FPU completion strobe, one cycle
- fpu_result  input  32  FPU result, valid in the cycle fpu_done=1
- result  output  32  latched result for display
- timeout  output  1  1 when the latched result came from a timeout
- busy  output  1  1 in IDLE, ISSUE and WAIT

## Operation
- States: IDLE, ISSUE, WAIT, SHOW (encoding from package).
- Reset: state=IDLE, vec_idx=0, fpu_start=0, result=32'h0, timeout=0, busy=1, wait counter=0, debouncer cleared (debounced level=0).
- IDLE: lasts exactly one cycle, then → ISSUE. This gives the operand table a full cycle to settle after an index change.
- ISSUE: fpu_start=1 for this one cycle, wait counter cleared, → WAIT. fpu_done is ignored in this state.
- WAIT:
  - fpu_done=1 → result<=fpu_result, timeout<=0, → SHOW.
  - Otherwise counter increments. When the counter reaches TIMEOUT_CYCLES-1 without done, result<=32'hFFFFFFFF, timeout<=1, → SHOW.
  - If done and the timeout condition occur in the same cycle, done wins.
- SHOW: busy=0; result and timeout held.
  - On btn_pulse: vec_idx<=(vec_idx==NUM_VECTORS-1)?0:vec_idx+1, → IDLE.
- vec_idx changes only on the SHOW→IDLE transition, so operands are stable from IDLE through WAIT.
- btn_pulse outside SHOW is dropped and not queued.
- fpu_done outside WAIT is ignored.
- Debounce path:
  - btn_raw passes through a 2-flop synchronizer.
  - Counter resets whenever the synchronized level equals the debounced level. When it differs for DEBOUNCE_CYCLES consecutive cycles, the debounced level is updated.
  - btn_pulse is a one-cycle strobe on the debounced rising edge.
  - Holding the button produces exactly one pulse; release produces none.

## Timing
- Raw rise to btn_pulse: DEBOUNCE_CYCLES+3 cycles for a clean press (2 sync + DEBOUNCE_CYCLES + 1 edge register).
- btn_pulse (in SHOW) → IDLE next cycle → ISSUE → fpu_start high 2 cycles after the pulse cycle.
- fpu_done in cycle t → result/timeout updated and state=SHOW at t+1; busy falls at t+1.
- Timeout: the result is latched exactly TIMEOUT_CYCLES cycles after the cycle following fpu_start.
- rst asserted in any state returns all outputs to reset values on the next edge. An in-flight FPU op is abandoned, and its late fpu_done lands in IDLE/ISSUE and is ignored.

## Structure
- Package fpu_test_pkg: state typedef (IDLE, ISSUE, WAIT, SHOW), TIMEOUT_RESULT=32'hFFFFFFFF, default NUM_VECTORS.
- Sub-module btn_debounce: synchronizer, stability counter and edge pulse. Parameter DEBOUNCE_CYCLES; ports clk, rst, btn_raw, btn_pulse.
- FSM, index counter, wait counter and result register live in fpu_test_sequencer.
- Benches override DEBOUNCE_CYCLES=4.

## Test plan
- Reset release, FPU model answers 3 cycles after start with 32'h40400000 → fpu_start pulses once at cycle 2 after reset; result=32'h40400000, timeout=0, vec_idx=0, busy=0.
- Ten button presses with FPU answering → vec_idx steps 1..9 then 0; exactly one fpu_start per press.
- FPU never answers, TIMEOUT_CYCLES=8 → result=32'hFFFFFFFF, timeout=1, state SHOW. The next press clears timeout on a good answer.
- Button bouncing (toggles every 2 cycles for 10 cycles, then held high 20 cycles) → exactly one btn_pulse and one index advance. A press during WAIT is ignored and the index is unchanged.
- fpu_done coincident with the timeout terminal count → real result latched, timeout=0. An fpu_done strobe during SHOW → result unchanged.
- rst asserted during WAIT at vec_idx=5, then late fpu_done with 32'h12345678 → vec_idx=0, result=0; the late done is ignored and a fresh fpu_start follows.

Source files
------------

// File: rtl/fpu_test_pkg.sv
// -----------------------------------------------------------------------------
// fpu_test_pkg
// Shared definitions for the FPU board-level test sequencer:
//   - seq_state_e         : sequencer FSM states
//   - TIMEOUT_RESULT      : value latched for display when the FPU never answers
//   - DEFAULT_NUM_VECTORS : default depth of the operand-pair table
// -----------------------------------------------------------------------------
package fpu_test_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        SHOW  = 2'd3
    } seq_state_e;

    localparam logic [31:0] TIMEOUT_RESULT      = 32'hFFFF_FFFF;
    localparam int          DEFAULT_NUM_VECTORS = 10;

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Turns a raw, bouncing, asynchronous push-button level into a single
// one-cycle strobe per accepted press.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous, active-high reset (clears debounced level)
//   btn_raw   in   asynchronous button level, active-high
//   btn_pulse out  one-cycle strobe on the debounced rising edge
//
// Latency for a clean press: 2 synchroniser cycles + DEBOUNCE_CYCLES stable
// cycles + 1 edge-detect register = DEBOUNCE_CYCLES+3 cycles.
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_dly_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;

            // Any cycle where the synchronised level agrees with the accepted
            // level restarts the stability window, so bounces never accumulate.
            if (sync2_q == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                level_q <= sync2_q;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end

            // Rising edge only: a held button gives one strobe, release gives none.
            level_dly_q <= level_q;
            pulse_q     <= level_q & ~level_dly_q;
        end
    end

    assign btn_pulse = pulse_q;

endmodule

// File: rtl/fpu_test_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_test_sequencer
// Steps the FPU through the stored operand-pair table, one vector per button
// press: addresses the operand table, issues a one-cycle start, waits for
// completion with a timeout, and latches the result for display.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   btn_raw    in   raw push-button level (debounced internally)
//   vec_idx    out  operand table address (table reads combinationally)
//   fpu_start  out  one-cycle start strobe to the FPU
//   fpu_done   in   one-cycle FPU completion strobe
//   fpu_result in   FPU result, valid while fpu_done=1
//   result     out  latched result for display
//   timeout    out  1 when the latched result came from a timeout
//   busy       out  1 in IDLE, ISSUE and WAIT; 0 in SHOW
// -----------------------------------------------------------------------------
module fpu_test_sequencer
    import fpu_test_pkg::*;
#(
    parameter int NUM_VECTORS     = DEFAULT_NUM_VECTORS,
    parameter int IDX_W           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    output logic [IDX_W-1:0] vec_idx,
    output logic             fpu_start,
    input  logic             fpu_done,
    input  logic [31:0]      fpu_result,
    output logic [31:0]      result,
    output logic             timeout,
    output logic             busy
);

    localparam int WCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_VECTORS - 1);

    seq_state_e        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_next_d;
    logic              start_q;
    logic [31:0]       result_q;
    logic              timeout_q;
    logic              busy_q;
    logic [WCNT_W-1:0] wait_cnt_q;
    logic              btn_pulse;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_pulse(btn_pulse)
    );

    // Table index with wrap at the last stored vector.
    always_comb begin
        idx_next_d = idx_q + 1'b1;
        if (idx_q == IDX_LAST) begin
            idx_next_d = '0;
        end
    end

    // All outputs are registered; each is set on the transition into the
    // state where it must be valid so it lines up exactly with that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            start_q    <= 1'b0;
            result_q   <= 32'h0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b1;
            wait_cnt_q <= '0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                // One settle cycle for the operand table after an index change.
                IDLE: begin
                    start_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    wait_cnt_q <= '0;
                    state_q    <= WAIT;
                end
                // A done arriving on the terminal count still wins.
                WAIT: begin
                    if (fpu_done) begin
                        result_q  <= fpu_result;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= SHOW;
                    end else if (wait_cnt_q == WCNT_LAST) begin
                        result_q  <= TIMEOUT_RESULT;
                        timeout_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= SHOW;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                // Presses outside SHOW are simply not looked at, hence dropped.
                SHOW: begin
                    if (btn_pulse) begin
                        idx_q   <= idx_next_d;
                        busy_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_idx   = idx_q;
    assign fpu_start = start_q;
    assign result    = result_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule
